// File: rtl/attack_score.sv
// attack_score
//   Consumes the per-square attack maps from the board attack stage and
//   produces a signed positional / king-safety score (white-positive).
//   A rising edge on is_attacking_done captures the maps, king squares and
//   check flags. The board is then walked one row per cycle, check
//   penalties are applied, and the result is presented with score_valid.
//
// Ports
//   clk                 clock
//   reset               asynchronous reset, active low
//   white_is_attacking  64-bit map, bit sq = row<<3|col attacked by white
//   black_is_attacking  64-bit map, squares attacked by black
//   white_in_check      white king is attacked
//   black_in_check      black king is attacked
//   is_attacking_done   level, high while the attack maps are valid
//   white_king_sq       white king square index
//   black_king_sq       black king square index
//   busy                computation in progress
//   score               signed score, white-positive
//   score_valid         score holds the result for the current board
module attack_score #(
   parameter int SCORE_WIDTH      = 12,
   parameter int CENTER_WEIGHT    = 2,
   parameter int KING_ZONE_WEIGHT = 3,
   parameter int CHECK_PENALTY    = 50
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [63:0]                   white_is_attacking,
   input  logic [63:0]                   black_is_attacking,
   input  logic                          white_in_check,
   input  logic                          black_in_check,
   input  logic                          is_attacking_done,
   input  logic [5:0]                    white_king_sq,
   input  logic [5:0]                    black_king_sq,
   output logic                          busy,
   output logic signed [SCORE_WIDTH-1:0] score,
   output logic                          score_valid
);

   // Row partial sums are kept at least 8 bits wide before accumulation.
   localparam int PART_W = (SCORE_WIDTH > 8) ? SCORE_WIDTH : 8;
   localparam logic signed [SCORE_WIDTH-1:0] PENALTY = SCORE_WIDTH'(CHECK_PENALTY);

   typedef enum logic [1:0] {IDLE, ROW, FINAL, DONE} state_t;

   state_t                        state;
   logic [2:0]                    row;
   logic                          done_prev;
   logic signed [SCORE_WIDTH-1:0] acc;
   logic signed [SCORE_WIDTH-1:0] acc_final;
   logic signed [PART_W-1:0]      row_sum;
   logic                          start;

   // Captured copies; only these feed the computation.
   logic [63:0] white_map;
   logic [63:0] black_map;
   logic        white_chk;
   logic        black_chk;
   logic [5:0]  white_king;
   logic [5:0]  black_king;

   // Chebyshev distance exactly 1; the king square itself is excluded.
   function automatic logic king_adjacent(input logic [5:0] sq, input logic [5:0] king);
      logic [2:0] dr;
      logic [2:0] dc;
      dr = (sq[5:3] > king[5:3]) ? (sq[5:3] - king[5:3]) : (king[5:3] - sq[5:3]);
      dc = (sq[2:0] > king[2:0]) ? (sq[2:0] - king[2:0]) : (king[2:0] - sq[2:0]);
      return (dr <= 3'd1) && (dc <= 3'd1) && !((dr == 3'd0) && (dc == 3'd0));
   endfunction

   // Signed contribution of one square: white term minus black term.
   // White attacks near the black king and black attacks near the white
   // king carry the extra king-zone weight on their own term.
   function automatic logic signed [PART_W-1:0] square_term(
      input logic [5:0] sq,
      input logic       w_bit,
      input logic       b_bit,
      input logic [5:0] w_king,
      input logic [5:0] b_king
   );
      int base;
      int w_weight;
      int b_weight;
      int term;
      base = 1;
      if (sq == 6'd27 || sq == 6'd28 || sq == 6'd35 || sq == 6'd36)
         base = base + CENTER_WEIGHT;
      w_weight = base;
      b_weight = base;
      if (king_adjacent(sq, b_king))
         w_weight = w_weight + KING_ZONE_WEIGHT;
      if (king_adjacent(sq, w_king))
         b_weight = b_weight + KING_ZONE_WEIGHT;
      term = (w_bit ? w_weight : 0) - (b_bit ? b_weight : 0);
      return PART_W'(term);
   endfunction

   assign start = is_attacking_done & ~done_prev;

   always_comb begin
      row_sum = '0;
      for (int c = 0; c < 8; c++) begin
         row_sum = row_sum + square_term({row, 3'(c)},
                                         white_map[{row, 3'(c)}],
                                         black_map[{row, 3'(c)}],
                                         white_king, black_king);
      end
   end

   always_comb begin
      acc_final = acc;
      if (white_chk)
         acc_final = acc_final - PENALTY;
      if (black_chk)
         acc_final = acc_final + PENALTY;
   end

   // Capture stage: board snapshot taken on the start cycle.
   always_ff @(posedge clk) begin
      if (start) begin
         white_map  <= white_is_attacking;
         black_map  <= black_is_attacking;
         white_chk  <= white_in_check;
         black_chk  <= black_in_check;
         white_king <= white_king_sq;
         black_king <= black_king_sq;
      end
   end

   // Control and accumulation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         row         <= '0;
         done_prev   <= 1'b0;
         acc         <= '0;
         score       <= '0;
         score_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         done_prev <= is_attacking_done;
         if (start) begin
            // A new start edge restarts from scratch in any state.
            acc         <= '0;
            row         <= '0;
            score_valid <= 1'b0;
            busy        <= 1'b1;
            state       <= ROW;
         end else begin
            case (state)
               IDLE: begin
                  busy <= 1'b0;
                  if (!is_attacking_done)
                     score_valid <= 1'b0;
               end
               ROW: begin
                  if (!is_attacking_done) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     acc <= acc + $signed(row_sum[SCORE_WIDTH-1:0]);
                     row <= row + 3'd1;
                     if (row == 3'd7)
                        state <= FINAL;
                  end
               end
               FINAL: begin
                  if (!is_attacking_done) begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     acc         <= acc_final;
                     score       <= acc_final;
                     score_valid <= 1'b1;
                     busy        <= 1'b0;
                     state       <= DONE;
                  end
               end
               DONE: begin
                  if (!is_attacking_done) begin
                     score_valid <= 1'b0;
                     state       <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
